traffic_request_gen: RTL and testbench

Request generator for the traffic light controller. It drives the controller FSM's `input_a` (side-road vehicle detector) and `input_b` (pedestrian push-button). Two raw asynchronous sensors are synchronised and debounced, each arrival is latched as a pending request, and the request is held until the FSM reports the matching phase as served. It also flags requests that have waited too long and keeps per-channel arrival counts for debug.

---
 rtl/traffic_request_gen_pkg.sv | 15 +
 rtl/traffic_request_gen_if.sv | 35 +++
 rtl/traffic_request_gen_channel.sv | 114 +++++++++++
 rtl/traffic_request_gen.sv | 41 ++++
 tb/tb_traffic_request_gen.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_request_gen_pkg.sv
// traffic_request_gen shared types and widths.
// Imported by the interface, the channel and the top.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    URGENT  = 2'd2
  } req_state_t;

  localparam int REQ_COUNT_W = 8;
  localparam int WAIT_CNT_W  = 16;
  localparam int DB_CNT_W    = 8;

endpackage

// File: rtl/traffic_request_gen_if.sv
// traffic_request_gen sensor/served/request bundle.
// master: environment side (drives raw sensors and served
//   flags); slave: the request generator (drives requests,
//   urgency flags and arrival counts).
interface traffic_request_gen_if;
  import traffic_pkg::*;

  logic                   raw_car_a;
  logic                   raw_ped_b;
  logic                   served_a;
  logic                   served_b;
  logic                   input_a;
  logic                   input_b;
  logic                   urgent_a;
  logic                   urgent_b;
  logic [REQ_COUNT_W-1:0] count_a;
  logic [REQ_COUNT_W-1:0] count_b;

  modport master (
    output raw_car_a, raw_ped_b,
    output served_a, served_b,
    input  input_a, input_b,
    input  urgent_a, urgent_b,
    input  count_a, count_b
  );

  modport slave (
    input  raw_car_a, raw_ped_b,
    input  served_a, served_b,
    output input_a, input_b,
    output urgent_a, urgent_b,
    output count_a, count_b
  );

endinterface

// File: rtl/traffic_request_gen_channel.sv
// traffic_req_channel: sync, debounce, request FSM, counters.
// Ports: clk, rstb (async high), i_raw (raw sensor),
//   i_served (phase served level), o_req (pending request),
//   o_urgent (waited too long), o_count (accepted arrivals).
module traffic_req_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rstb,
  input  logic                   i_raw,
  input  logic                   i_served,
  output logic                   o_req,
  output logic                   o_urgent,
  output logic [REQ_COUNT_W-1:0] o_count
);

  localparam logic [DB_CNT_W-1:0] DB_LAST =
    DB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
    WAIT_CNT_W'(MAX_WAIT_CYCLES - 1);

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_deb;
  logic                   r_deb_q;
  logic [DB_CNT_W-1:0]    r_db_cnt;
  req_state_t             r_state;
  logic [WAIT_CNT_W-1:0]  r_wait_cnt;
  logic [REQ_COUNT_W-1:0] r_count;

  req_state_t w_next;
  logic       w_rise;
  logic       w_accept;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_deb    <= 1'b0;
      r_deb_q  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      if (r_sync2 == r_deb) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_deb    <= ~r_deb;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_q;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Served wins over the urgent promotion; a rise during
  // green or while already waiting is absorbed.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_rise && !i_served) w_next = PENDING;
      end
      PENDING: begin
        if (i_served)                  w_next = IDLE;
        else if (r_wait_cnt == WAIT_LAST) w_next = URGENT;
      end
      URGENT: begin
        if (i_served) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_accept = (r_state == IDLE) && (w_next == PENDING);

  // Wait count is zero whenever the channel is (or is about
  // to be) idle, so entry to PENDING always starts from zero.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_wait_cnt <= '0;
      r_count    <= '0;
    end else begin
      if (r_state == IDLE || w_next == IDLE) begin
        r_wait_cnt <= '0;
      end else if (r_state == PENDING &&
                   r_wait_cnt != WAIT_LAST) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_accept) r_count <= r_count + 1'b1;
    end
  end

  always_comb begin
    o_req    = (r_state != IDLE);
    o_urgent = (r_state == URGENT);
    o_count  = r_count;
  end

endmodule

// File: rtl/traffic_request_gen.sv
// traffic_request_gen: request front end for the light FSM.
// Ports: clk, rstb (async high), bus (slave modport carrying
//   raw sensors, served flags, requests, urgency, counts).
module traffic_request_gen
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rstb,
  traffic_request_gen_if.slave bus
);

  traffic_req_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .MAX_WAIT_CYCLES (MAX_WAIT_CYCLES)
  ) u_ch_a (
    .clk      (clk),
    .rstb     (rstb),
    .i_raw    (bus.raw_car_a),
    .i_served (bus.served_a),
    .o_req    (bus.input_a),
    .o_urgent (bus.urgent_a),
    .o_count  (bus.count_a)
  );

  traffic_req_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .MAX_WAIT_CYCLES (MAX_WAIT_CYCLES)
  ) u_ch_b (
    .clk      (clk),
    .rstb     (rstb),
    .i_raw    (bus.raw_ped_b),
    .i_served (bus.served_b),
    .o_req    (bus.input_b),
    .o_urgent (bus.urgent_b),
    .o_count  (bus.count_b)
  );

endmodule

// File: tb/tb_traffic_request_gen.sv
// tb_traffic_request_gen: scoreboard bench for the request
// generator with a window-based reference model.
module tb_traffic_request_gen;

  localparam int D    = 4;
  localparam int M    = 16;
  localparam int LOGN = 32768;

  typedef struct packed {
    logic       ia;
    logic       ib;
    logic       ua;
    logic       ub;
    logic [7:0] ca;
    logic [7:0] cb;
  } exp_t;

  logic clk;
  logic rstb;

  traffic_request_gen_if u_if ();

  traffic_request_gen #(
    .DEBOUNCE_CYCLES (D),
    .MAX_WAIT_CYCLES (M)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: edge-indexed log of raw samples; the
  // debounced level flips when the last D synchronised samples
  // (raw delayed two edges, zero before reset release) all
  // disagree with it; requests tracked as pending + age.
  bit rawlog [2][LOGN];
  int e        = 0;
  int last_rst = 0;
  bit m_deb  [2];
  bit m_rose [2];
  bit m_pend [2];
  int m_age  [2];
  int m_cnt  [2];
  exp_t sbq[$];

  function automatic bit seen(int ch, int j);
    if (j - 2 > last_rst) return rawlog[ch][j-2];
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit   srv [2];
    exp_t x;
    e++;
    if (e >= LOGN) $fatal(1, "FAIL model_log: edge log full");
    rawlog[0][e] = u_if.raw_car_a;
    rawlog[1][e] = u_if.raw_ped_b;
    srv[0] = u_if.served_a;
    srv[1] = u_if.served_b;
    for (int ch = 0; ch < 2; ch++) begin
      if (rstb) begin
        last_rst   = e;
        m_deb[ch]  = 0;
        m_rose[ch] = 0;
        m_pend[ch] = 0;
        m_age[ch]  = 0;
        m_cnt[ch]  = 0;
      end else begin
        bit rise;
        bit flip;
        rise = m_rose[ch];
        flip = 1;
        for (int i = 0; i < D; i++) begin
          if (!(e - i > last_rst) || seen(ch, e - i) == m_deb[ch])
            flip = 0;
        end
        if (flip) m_deb[ch] = !m_deb[ch];
        m_rose[ch] = flip && m_deb[ch];
        if (m_pend[ch] && srv[ch]) begin
          m_pend[ch] = 0;
          m_age[ch]  = 0;
        end else if (!m_pend[ch] && rise && !srv[ch]) begin
          m_pend[ch] = 1;
          m_age[ch]  = 0;
          m_cnt[ch]  = (m_cnt[ch] + 1) % 256;
        end else if (m_pend[ch]) begin
          m_age[ch]++;
        end
      end
    end
    x.ia = m_pend[0];
    x.ib = m_pend[1];
    x.ua = m_pend[0] && (m_age[0] >= M);
    x.ub = m_pend[1] && (m_age[1] >= M);
    x.ca = 8'(m_cnt[0]);
    x.cb = 8'(m_cnt[1]);
    sbq.push_back(x);
  end

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t x;
      exp_t a;
      x = sbq.pop_front();
      a.ia = u_if.input_a;
      a.ib = u_if.input_b;
      a.ua = u_if.urgent_a;
      a.ub = u_if.urgent_b;
      a.ca = u_if.count_a;
      a.cb = u_if.count_b;
      chk("scoreboard", 32'(a), 32'(x));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {u_if.input_a, u_if.input_b, u_if.urgent_a,
             u_if.urgent_b, u_if.count_a, u_if.count_b}, 0);
  endtask

  initial begin
    rstb = 1'b1;
    u_if.raw_car_a = 1'b0;
    u_if.raw_ped_b = 1'b0;
    u_if.served_a  = 1'b0;
    u_if.served_b  = 1'b0;
    tick(3);
    chk_all_zero("reset_state");
    rstb = 1'b0;
    tick(3);

    // Clean arrival on A.
    u_if.raw_car_a = 1'b1;
    edges(6);
    chk("arrive_a_edge6", u_if.input_a, 0);
    edges(1);
    chk("arrive_a_edge7", u_if.input_a, 1);
    chk("arrive_a_count", u_if.count_a, 1);
    chk("arrive_a_b_idle", u_if.input_b, 0);

    // Urgency 16 edges after the request, then serve.
    edges(15);
    chk("urgent_a_edge15", u_if.urgent_a, 0);
    edges(1);
    chk("urgent_a_edge16", u_if.urgent_a, 1);
    tick(1);
    u_if.served_a = 1'b1;
    edges(1);
    chk("serve_a_req", u_if.input_a, 0);
    chk("serve_a_urg", u_if.urgent_a, 0);
    tick(1);
    u_if.served_a  = 1'b0;
    u_if.raw_car_a = 1'b0;
    tick(10);

    // Bounce on B, ending low, then settle high.
    for (int c = 0; c < 40;) begin
      int h;
      int l;
      h = $urandom_range(1, 3);
      l = $urandom_range(1, 3);
      u_if.raw_ped_b = 1'b1;
      tick(h);
      u_if.raw_ped_b = 1'b0;
      tick(l);
      c += h + l;
    end
    chk("bounce_b_none", u_if.input_b, 0);
    u_if.raw_ped_b = 1'b1;
    edges(6);
    chk("settle_b_edge6", u_if.input_b, 0);
    edges(1);
    chk("settle_b_edge7", u_if.input_b, 1);
    chk("settle_b_count", u_if.count_b, 1);

    // Arrival during green on A, then a merged rise.
    tick(1);
    u_if.served_a  = 1'b1;
    u_if.raw_car_a = 1'b1;
    tick(12);
    chk("green_a_req", u_if.input_a, 0);
    chk("green_a_count", u_if.count_a, 1);
    u_if.served_a  = 1'b0;
    tick(3);
    u_if.raw_car_a = 1'b0;
    tick(9);
    u_if.raw_car_a = 1'b1;
    tick(9);
    chk("second_a_req", u_if.input_a, 1);
    u_if.raw_car_a = 1'b0;
    tick(9);
    u_if.raw_car_a = 1'b1;
    tick(9);
    chk("merge_a_count", u_if.count_a, 2);
    u_if.served_a = 1'b1;
    tick(1);
    u_if.served_a  = 1'b0;
    u_if.raw_car_a = 1'b0;
    tick(9);

    // Reset in the middle of an urgent B request.
    chk("pre_reset_urg_b", u_if.urgent_b, 1);
    rstb = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick(2);
    rstb = 1'b0;
    edges(6);
    chk("rerun_b_edge6", u_if.input_b, 0);
    edges(1);
    chk("rerun_b_edge7", u_if.input_b, 1);
    chk("rerun_b_count", u_if.count_b, 1);
    tick(1);
    u_if.served_b  = 1'b1;
    tick(1);
    u_if.served_b  = 1'b0;
    u_if.raw_ped_b = 1'b0;
    tick(9);

    // 256 arrive/serve rounds on A.
    for (int k = 0; k < 256; k++) begin
      u_if.raw_car_a = 1'b1;
      tick($urandom_range(8, 12));
      u_if.served_a = 1'b1;
      tick(1);
      u_if.served_a  = 1'b0;
      u_if.raw_car_a = 1'b0;
      tick($urandom_range(7, 9));
    end
    chk("wrap_a_count", u_if.count_a, 0);
    chk("wrap_a_req", u_if.input_a, 0);
    chk("wrap_b_count", u_if.count_b, 1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0)
        u_if.raw_car_a = !u_if.raw_car_a;
      if ($urandom_range(0, 5) == 0)
        u_if.raw_ped_b = !u_if.raw_ped_b;
      u_if.served_a = ($urandom_range(0, 19) == 0);
      u_if.served_b = ($urandom_range(0, 24) == 0);
      rstb = ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rstb = 1'b0;
    tick(3);
    chk("scoreboard_drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
